branch_pred: RTL and testbench
==============================

# branch_pred

- Dynamic branch predictor feeding the next-PC selector.
- Each cycle it looks up the fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- A hit that predicts taken drives `BP_WR` and `PC_BP` to the next-PC mux.
- It carries the prediction into D, trains on the resolved D-stage outcome, and flags mispredictions to the redirect logic.

## Interface

Parameters:
- `ENTRIES`, default 16: BTB entries; power of two, minimum 4.
- `IDX_W`, default 4: log2(`ENTRIES`). Index is `PC[IDX_W+1:2]`; tag is `PC[31:IDX_W+2]`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `PC`  in  32: current fetch PC.
- `stall`  in  1: pipeline stall; freezes the D-stage prediction registers and blocks training.
- `flush`  in  1: exception or eret or redirect; clears the D-stage prediction.
- `PC_D`  in  32: address of the instruction in D.
- `br_D`  in  1: the instruction in D is a branch or jump whose outcome is resolved this cycle.
- `taken_D`  in  1: resolved direction.
- `target_D`  in  32: resolved target.
- `PC_BP`  out  32: predicted next PC.
- `BP_WR`  out  1: prediction valid (hit and predicted taken).
- `pred_D`  out  1: registered `BP_WR` for the instruction in D.
- `pred_tgt_D`  out  32: registered `PC_BP` for the instruction in D.
- `mispred_D`  out  1: the prediction for the instruction in D was wrong.

## Operation

- **Entry contents:** `valid`, `tag`, `target[31:2]`, `ctr[1:0]`.
- **Counter encoding:** 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- **Lookup (combinational):**
  - `hit = valid[idx] & (tag[idx] == PC tag)`.
  - `BP_WR = hit & ctr[idx][1]`.
  - `PC_BP = BP_WR ? {target,2'b00} : PC + 4` (32-bit wrap).
- **D-stage registers `pred_D` / `pred_tgt_D`:**
  - `flush=1`: load 0 / 0. Flush wins over stall.
  - `stall=1`: hold.
  - Otherwise: load `BP_WR` / `PC_BP`.
- **Training** (`upd = ~stall`, index and tag taken from `PC_D`):
  - `br_D & hit_D` (tag match at the `PC_D` index): counter increments on taken and decrements on not-taken, saturating at 11 and 00. When taken, target is overwritten with `target_D[31:2]`.
  - `br_D & ~hit_D & taken_D`: allocate the entry: valid=1, tag, target, ctr=10.
  - `br_D & ~hit_D & ~taken_D`: no write.
  - `~br_D & pred_D`: the prediction was an alias on a non-branch; clear `valid` at the `PC_D` index.
- **Misprediction (combinational, forced to 0 while `stall=1`):**
  - `mispred_D = br_D ? (taken_D ? (~pred_D | target_D != pred_tgt_D) : pred_D) : pred_D`.
- **Same-cycle lookup and write to the same index:** lookup returns the pre-write contents; the write is visible from the next cycle.
- **Reset:**
  - All table state: `valid=0`, `ctr=01`.
  - `pred_D=0`, `pred_tgt_D=0`.
  - Outputs therefore reset to `BP_WR=0`, `PC_BP=PC+4`, `mispred_D=0`.
  - `tag`/`target` are not cleared, since `valid=0` masks them.

## Timing

- Lookup is zero-latency: `PC` to `PC_BP`/`BP_WR` in the same cycle. The combinational path must fit ahead of the next-PC mux.
- `pred_D`/`pred_tgt_D` follow `BP_WR`/`PC_BP` by one cycle, aligned with the F→D pipeline register.
- A training write at edge N affects the lookup from cycle N+1.
- `mispred_D` depends on D-stage inputs in the same cycle; the redirect logic registers it.
- Asserting `rst_n` in the middle of a run clears all valid bits and the D registers immediately, without waiting for a clock edge. `BP_WR` drops in the same cycle.

## Structure

- Shared package `bp_pkg`:
  - counter encodings `CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`;
  - allocation value `CTR_ALLOC = CTR_WT`;
  - reset value `CTR_RST = CTR_WNT`;
  - saturating-update function `ctr_next(ctr, taken)`.
- One sub-module, `bp_table`:
  - storage plus a combinational read port (fetch `PC`) and a probe port (`PC_D`, used for `hit_D`);
  - one synchronous write port.
- The top level `branch_pred` holds the D registers, training control and misprediction compare.

## Test plan

Defaults for all scenarios: `ENTRIES=16`; index `PC[5:2]`.

1. **Reset:** hold `rst_n=0` with `PC=0xBFC00000` → `BP_WR=0`, `PC_BP=0xBFC00004`, `pred_D=0`, `mispred_D=0`.
2. **Allocate:** `br_D=1`, `taken_D=1`, `PC_D=0xBFC00010`, `target_D=0xBFC00100`, `stall=0` → `mispred_D=1` in that cycle. Next cycle, `PC=0xBFC00010` → `BP_WR=1`, `PC_BP=0xBFC00100`.
3. **Hysteresis** on that entry (starts at ctr=10):
   - not-taken → ctr=01, `BP_WR=0`;
   - taken twice → ctr=11;
   - not-taken → ctr=10, `BP_WR` stays 1;
   - five taken in a row saturate at 11.
4. **Alias:**
   - `PC=0xBFC00410` (same index, different tag) → `BP_WR=0`.
   - A forced `pred_D=1` with `br_D=0` at `PC_D=0xBFC00010` → `mispred_D=1`; the entry is invalidated and the next lookup of `0xBFC00010` gives `BP_WR=0`.
5. **Stall/flush:**
   - `stall=1` with `br_D=1` → `pred_D` holds, `mispred_D=0`, no counter change.
   - `stall=1`, `flush=1` → `pred_D=0` next cycle.
6. **Reset mid-run:** with trained entries and `pred_D=1`, drop `rst_n` between clock edges → `BP_WR`, `pred_D` and `mispred_D` go to 0 immediately, and every entry misses after release.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and
// the saturating counter update used when training.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT   = 2'b00;
  localparam ctr_t CTR_WNT   = 2'b01;
  localparam ctr_t CTR_WT    = 2'b10;
  localparam ctr_t CTR_ST    = 2'b11;
  localparam ctr_t CTR_ALLOC = CTR_WT;
  localparam ctr_t CTR_RST   = CTR_WNT;

  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    if (taken)
      return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    else
      return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped BTB storage: combinational fetch lookup, combinational probe
// for the D-stage PC, and one synchronous write port.
module bp_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  localparam int TAG_W  = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output ctr_t             rd_ctr,
  output logic [29:0]      rd_tgt,
  input  logic [IDX_W-1:0] pr_idx,
  input  logic [TAG_W-1:0] pr_tag,
  output logic             pr_hit,
  output ctr_t             pr_ctr,
  output logic [29:0]      pr_tgt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_valid,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [29:0]      wr_tgt,
  input  ctr_t             wr_ctr
);

  logic             valid_q [ENTRIES];
  ctr_t             ctr_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [29:0]      tgt_q   [ENTRIES];

  // Only valid/ctr are reset; stale tag/target are masked by valid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RST;
      end
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
      ctr_q[wr_idx]   <= wr_ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
      tgt_q[wr_idx] <= wr_tgt;
    end
  end

  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_ctr = ctr_q[rd_idx];
  assign rd_tgt = tgt_q[rd_idx];

  assign pr_hit = valid_q[pr_idx] && (tag_q[pr_idx] == pr_tag);
  assign pr_ctr = ctr_q[pr_idx];
  assign pr_tgt = tgt_q[pr_idx];

endmodule

// File: rtl/branch_pred.sv
// Dynamic branch predictor: zero-latency BTB lookup for the next-PC mux,
// D-stage prediction registers, training and misprediction detection.
module branch_pred
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] PC_D,
  input  logic        br_D,
  input  logic        taken_D,
  input  logic [31:0] target_D,
  output logic [31:0] PC_BP,
  output logic        BP_WR,
  output logic        pred_D,
  output logic [31:0] pred_tgt_D,
  output logic        mispred_D
);

  localparam int TAG_W = 30 - IDX_W;

  logic             rd_hit;
  ctr_t             rd_ctr;
  logic [29:0]      rd_tgt;
  logic             hit_D;
  ctr_t             pr_ctr;
  logic [29:0]      pr_tgt;
  logic             wr_en;
  logic             wr_valid;
  ctr_t             wr_ctr;
  logic [29:0]      wr_tgt;
  logic             unused_pc_d_lsb;

  assign unused_pc_d_lsb = ^PC_D[1:0];

  bp_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (PC[IDX_W+1:2]),
    .rd_tag   (PC[31:IDX_W+2]),
    .rd_hit   (rd_hit),
    .rd_ctr   (rd_ctr),
    .rd_tgt   (rd_tgt),
    .pr_idx   (PC_D[IDX_W+1:2]),
    .pr_tag   (PC_D[31:IDX_W+2]),
    .pr_hit   (hit_D),
    .pr_ctr   (pr_ctr),
    .pr_tgt   (pr_tgt),
    .wr_en    (wr_en),
    .wr_idx   (PC_D[IDX_W+1:2]),
    .wr_valid (wr_valid),
    .wr_tag   (PC_D[31:IDX_W+2]),
    .wr_tgt   (wr_tgt),
    .wr_ctr   (wr_ctr)
  );

  assign BP_WR = rd_hit & rd_ctr[1];
  assign PC_BP = BP_WR ? {rd_tgt, 2'b00} : PC + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_D     <= 1'b0;
      pred_tgt_D <= 32'd0;
    end else if (flush) begin
      pred_D     <= 1'b0;
      pred_tgt_D <= 32'd0;
    end else if (!stall) begin
      pred_D     <= BP_WR;
      pred_tgt_D <= PC_BP;
    end
  end

  // Training: existing entries keep their target unless the branch was taken.
  always_comb begin
    wr_en    = 1'b0;
    wr_valid = 1'b1;
    wr_ctr   = pr_ctr;
    wr_tgt   = pr_tgt;
    if (!stall) begin
      if (br_D) begin
        if (hit_D) begin
          wr_en  = 1'b1;
          wr_ctr = ctr_next(pr_ctr, taken_D);
          if (taken_D) wr_tgt = target_D[31:2];
        end else if (taken_D) begin
          wr_en  = 1'b1;
          wr_ctr = CTR_ALLOC;
          wr_tgt = target_D[31:2];
        end
      end else if (pred_D) begin
        wr_en    = 1'b1;
        wr_valid = 1'b0;
      end
    end
  end

  always_comb begin
    mispred_D = 1'b0;
    if (!stall) begin
      if (br_D)
        mispred_D = taken_D ? (~pred_D | (target_D != pred_tgt_D)) : pred_D;
      else
        mispred_D = pred_D;
    end
  end

endmodule

// File: tb/tb_branch_pred.sv
// Randomised scoreboard bench for branch_pred: a behavioural BTB model
// predicts each cycle's outputs, a monitor compares them against the DUT.
module tb_branch_pred;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] PC = 32'd0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] PC_D = 32'd0;
  logic        br_D = 1'b0;
  logic        taken_D = 1'b0;
  logic [31:0] target_D = 32'd0;
  logic [31:0] PC_BP;
  logic        BP_WR;
  logic        pred_D;
  logic [31:0] pred_tgt_D;
  logic        mispred_D;

  always #5 clk = ~clk;

  branch_pred #(.ENTRIES(16), .IDX_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PC         (PC),
    .stall      (stall),
    .flush      (flush),
    .PC_D       (PC_D),
    .br_D       (br_D),
    .taken_D    (taken_D),
    .target_D   (target_D),
    .PC_BP      (PC_BP),
    .BP_WR      (BP_WR),
    .pred_D     (pred_D),
    .pred_tgt_D (pred_tgt_D),
    .mispred_D  (mispred_D)
  );

  typedef struct {
    logic        bp_wr;
    logic [31:0] pc_bp;
    logic        pred;
    logic [31:0] pred_tgt;
    logic        mis;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;
  bit   drv_rst = 1'b0;

  // Reference model: an abstract table of 16 BTB slots with integer counters.
  bit          m_valid [16];
  bit [25:0]   m_tag   [16];
  bit [31:0]   m_tgt   [16];
  int          m_ctr   [16];
  bit          m_pred;
  bit [31:0]   m_ptgt;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_pred = 1'b0;
    m_ptgt = 32'd0;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    int   i;
    bit   looked_up;
    bit   actual_taken;
    i = int'(PC[5:2]);
    looked_up = m_valid[i] && (m_tag[i] == PC[31:6]);
    e.bp_wr = looked_up && (m_ctr[i] >= 2);
    e.pc_bp = e.bp_wr ? m_tgt[i] : PC + 32'd4;
    e.pred = m_pred;
    e.pred_tgt = m_ptgt;
    actual_taken = br_D && taken_D;
    e.mis = !stall && ((m_pred != actual_taken) || (actual_taken && target_D != m_ptgt));
    e.id = txn;
    return e;
  endfunction

  function automatic void model_clock(input exp_t e);
    int j;
    bit dhit;
    j = int'(PC_D[5:2]);
    dhit = m_valid[j] && (m_tag[j] == PC_D[31:6]);
    if (!stall) begin
      if (br_D && dhit) begin
        m_ctr[j] = taken_D ? ((m_ctr[j] < 3) ? m_ctr[j] + 1 : 3)
                           : ((m_ctr[j] > 0) ? m_ctr[j] - 1 : 0);
        if (taken_D) m_tgt[j] = target_D & 32'hFFFF_FFFC;
      end else if (br_D && taken_D) begin
        m_valid[j] = 1'b1;
        m_tag[j]   = PC_D[31:6];
        m_tgt[j]   = target_D & 32'hFFFF_FFFC;
        m_ctr[j]   = 2;
      end else if (!br_D && m_pred) begin
        m_valid[j] = 1'b0;
      end
    end
    if (flush) begin
      m_pred = 1'b0;
      m_ptgt = 32'd0;
    end else if (!stall) begin
      m_pred = e.bp_wr;
      m_ptgt = e.pc_bp;
    end
  endfunction

  task automatic step(input logic [31:0] pc, input bit st, input bit fl,
                      input logic [31:0] pcd, input bit br, input bit tk,
                      input logic [31:0] tgt);
    exp_t e;
    @(negedge clk);
    rst_n = drv_rst; PC = pc; stall = st; flush = fl;
    PC_D = pcd; br_D = br; taken_D = tk; target_D = tgt;
    e = expect_now();
    sb.push_back(e);
    txn++;
    if (rst_n) model_clock(e);
    else model_reset();
  endtask

  // Drops reset between clock edges and expects the outputs to clear at once.
  task automatic reset_pulse();
    exp_t e;
    @(negedge clk);
    #1;
    rst_n = 1'b0; drv_rst = 1'b0;
    br_D = 1'b0; stall = 1'b0; flush = 1'b0;
    model_reset();
    e = expect_now();
    sb.push_back(e);
    txn++;
  endtask

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s txn %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        $display("txn %0d PC=%h PC_D=%h br=%b tk=%b st=%b fl=%b -> BP_WR=%b PC_BP=%h pred_D=%b mis=%b",
                 e.id, PC, PC_D, br_D, taken_D, stall, flush, BP_WR, PC_BP, pred_D, mispred_D);
        chk("BP_WR", e.id, {31'd0, BP_WR}, {31'd0, e.bp_wr});
        chk("PC_BP", e.id, PC_BP, e.pc_bp);
        chk("pred_D", e.id, {31'd0, pred_D}, {31'd0, e.pred});
        chk("pred_tgt_D", e.id, pred_tgt_D, e.pred_tgt);
        chk("mispred_D", e.id, {31'd0, mispred_D}, {31'd0, e.mis});
      end
    end
  end

  localparam logic [31:0] A = 32'hBFC0_0010;
  localparam logic [31:0] T = 32'hBFC0_0100;

  logic [31:0] tgt_pool [4] = '{32'hBFC0_0100, 32'hBFC0_0200, 32'h8000_0000, 32'hBFC0_0104};

  function automatic logic [31:0] rand_pc();
    return 32'hBFC0_0000 | (32'($urandom_range(0, 1)) << 10) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin : stimulus
    model_reset();
    // Reset held
    step(32'hBFC0_0000, 0, 0, 32'd0, 0, 0, 32'd0);
    step(32'hBFC0_0000, 0, 0, 32'd0, 0, 0, 32'd0);
    drv_rst = 1'b1;
    // Allocate, then hit next cycle
    step(32'hBFC0_0000, 0, 0, A, 1, 1, T);
    step(A, 0, 0, 32'd0, 0, 0, 32'd0);
    // Hysteresis: NT, T, T, NT, then five T
    step(A, 0, 0, A, 1, 0, T);
    step(A, 0, 0, A, 1, 1, T);
    step(A, 0, 0, A, 1, 1, T);
    step(A, 0, 0, A, 1, 0, T);
    repeat (5) step(A, 0, 0, A, 1, 1, T);
    // Alias: other tag misses; non-branch with pred_D=1 invalidates
    step(32'hBFC0_0410, 0, 0, 32'd0, 0, 0, 32'd0);
    step(A, 0, 0, 32'd0, 0, 0, 32'd0);
    step(A, 0, 0, A, 0, 0, 32'd0);
    step(A, 0, 0, 32'd0, 0, 0, 32'd0);
    // Stall/flush
    step(32'hBFC0_0000, 0, 0, A, 1, 1, T);
    step(A, 0, 0, 32'd0, 0, 0, 32'd0);
    step(32'hBFC0_0000, 1, 0, A, 1, 0, T);
    step(A, 1, 0, A, 1, 0, T);
    step(A, 1, 1, A, 1, 1, T);
    step(A, 0, 0, 32'd0, 0, 0, 32'd0);
    // Random traffic
    for (int n = 0; n < 300; n++) begin
      step(rand_pc(), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
           rand_pc(), ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
           tgt_pool[$urandom_range(0, 3)]);
    end
    // Reset mid-run with a trained entry and pred_D=1
    step(32'hBFC0_0000, 0, 0, A, 1, 1, T);
    step(A, 0, 0, 32'd0, 0, 0, 32'd0);
    step(A, 0, 0, 32'd0, 0, 0, 32'd0);
    reset_pulse();
    step(A, 0, 0, 32'd0, 0, 0, 32'd0);
    drv_rst = 1'b1;
    for (int k = 0; k < 16; k++) step(32'hBFC0_0000 | (32'(k) << 2), 0, 0, 32'd0, 0, 0, 32'd0);
    for (int k = 0; k < 16; k++) step(32'hBFC0_0400 | (32'(k) << 2), 0, 0, 32'd0, 0, 0, 32'd0);
    @(negedge clk);
    #4;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
